// File: rtl/cram_burst_arbiter.sv
// Two-port round-robin arbiter in front of the burst-mode cellular RAM controller.
// Captures the winner's address/data and drives CE for exactly one burst.
module cram_burst_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 8
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Req0,
    input  logic [19:0] Addr0,
    input  logic [15:0] Data0,
    input  logic        Req1,
    input  logic [19:0] Addr1,
    input  logic [15:0] Data1,
    output logic        Grant0,
    output logic        Grant1,
    output logic        Done0,
    output logic        Done1,
    output logic        TimeoutErr,
    output logic [19:0] MemAddressOut,
    output logic [15:0] MemDataOut,
    output logic        MemCE,
    input  logic        MemYield,
    input  logic        MemDone
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_q;
    logic [TO_W-1:0] cnt_q;
    logic        grant0_q;
    logic        grant1_q;
    logic        done0_q;
    logic        done1_q;
    logic        tout_q;
    logic        ce_q;
    logic [19:0] addr_q;
    logic [15:0] data_q;

    logic start_d;
    logic win1_d;
    logic tmo_d;

    // On a tie the requester that did not win last time goes next.
    assign start_d = (Req0 | Req1) & MemYield;
    assign win1_d  = Req1 & (~Req0 | ~last_q);
    assign tmo_d   = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            tout_q   <= 1'b0;
            ce_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            tout_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_d) begin
                        grant0_q <= ~win1_d;
                        grant1_q <= win1_d;
                        ce_q     <= 1'b1;
                        last_q   <= win1_d;
                        cnt_q    <= '0;
                        addr_q   <= win1_d ? Addr1 : Addr0;
                        data_q   <= win1_d ? Data1 : Data0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    // MemDone takes priority over a coincident timeout.
                    if (MemDone || tmo_d) begin
                        ce_q     <= 1'b0;
                        grant0_q <= 1'b0;
                        grant1_q <= 1'b0;
                        done0_q  <= grant0_q;
                        done1_q  <= grant1_q;
                        tout_q   <= ~MemDone;
                        state_q  <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Grant0        = grant0_q;
    assign Grant1        = grant1_q;
    assign Done0         = done0_q;
    assign Done1         = done1_q;
    assign TimeoutErr    = tout_q;
    assign MemCE         = ce_q;
    assign MemAddressOut = addr_q;
    assign MemDataOut    = data_q;

endmodule

// File: tb/tb_cram_burst_arbiter.sv
// Directed bench for cram_burst_arbiter with TIMEOUT_CYCLES=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_cram_burst_arbiter;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req0 = 1'b0;
    logic [19:0] Addr0 = '0;
    logic [15:0] Data0 = '0;
    logic        Req1 = 1'b0;
    logic [19:0] Addr1 = '0;
    logic [15:0] Data1 = '0;
    logic        Grant0, Grant1, Done0, Done1, TimeoutErr, MemCE;
    logic [19:0] MemAddressOut;
    logic [15:0] MemDataOut;
    logic        MemYield = 1'b0;
    logic        MemDone = 1'b0;

    int checks = 0;
    int failures = 0;

    cram_burst_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(8)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .Req0(Req0), .Addr0(Addr0), .Data0(Data0),
        .Req1(Req1), .Addr1(Addr1), .Data1(Data1),
        .Grant0(Grant0), .Grant1(Grant1),
        .Done0(Done0), .Done1(Done1), .TimeoutErr(TimeoutErr),
        .MemAddressOut(MemAddressOut), .MemDataOut(MemDataOut),
        .MemCE(MemCE), .MemYield(MemYield), .MemDone(MemDone)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    // Invariants: exclusive grants, CE only with a grant, Done never two cycles.
    logic d0_prev = 1'b0;
    logic d1_prev = 1'b0;
    always @(negedge CLK) begin
        if (Reset_n) begin
            checks++;
            if ((Grant0 && Grant1) || (MemCE !== (Grant0 | Grant1))) begin
                failures++;
                $display("FAIL invariant_grant g0=%b g1=%b ce=%b required exclusive grants with ce=g0|g1",
                         Grant0, Grant1, MemCE);
            end
            checks++;
            if ((d0_prev && Done0) || (d1_prev && Done1)) begin
                failures++;
                $display("FAIL invariant_done_len done0=%b done1=%b held over two cycles, required one",
                         Done0, Done1);
            end
        end
        d0_prev = Done0;
        d1_prev = Done1;
    end

    task automatic test_reset();
        Reset_n = 1'b0;
        tick(); tick();
        checks++;
        if ({Grant0, Grant1, Done0, Done1, TimeoutErr, MemCE, MemAddressOut, MemDataOut} !== '0) begin
            failures++;
            $display("FAIL reset_outputs g0=%b g1=%b d0=%b d1=%b to=%b ce=%b a=%h d=%h required all 0",
                     Grant0, Grant1, Done0, Done1, TimeoutErr, MemCE, MemAddressOut, MemDataOut);
        end
        Reset_n = 1'b1;
        MemDone = 1'b1;
        tick(); tick();
        checks++;
        if (MemCE !== 1'b0 || Done0 !== 1'b0 || Done1 !== 1'b0) begin
            failures++;
            $display("FAIL idle_memdone ce=%b d0=%b d1=%b required 0 0 0", MemCE, Done0, Done1);
        end
        MemDone = 1'b0;
    endtask

    task automatic test_single();
        Req0 = 1'b1; Addr0 = 20'h00100; Data0 = 16'hBEEF; MemYield = 1'b1;
        tick();
        checks++;
        if (Grant0 !== 1'b1 || Grant1 !== 1'b0 || MemCE !== 1'b1) begin
            failures++;
            $display("FAIL single_grant g0=%b g1=%b ce=%b required 1 0 1", Grant0, Grant1, MemCE);
        end
        checks++;
        if (MemAddressOut !== 20'h00100 || MemDataOut !== 16'hBEEF) begin
            failures++;
            $display("FAIL single_addr_data a=%h d=%h required 00100 beef", MemAddressOut, MemDataOut);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (MemCE !== 1'b1 || Done0 !== 1'b0) begin
            failures++;
            $display("FAIL single_busy ce=%b d0=%b required 1 0", MemCE, Done0);
        end
        MemDone = 1'b1;
        tick();
        checks++;
        if (Done0 !== 1'b1 || TimeoutErr !== 1'b0 || MemCE !== 1'b0 || Grant0 !== 1'b0) begin
            failures++;
            $display("FAIL single_done d0=%b to=%b ce=%b g0=%b required 1 0 0 0",
                     Done0, TimeoutErr, MemCE, Grant0);
        end
        MemDone = 1'b0; Req0 = 1'b0;
        tick();
        checks++;
        if (Done0 !== 1'b0 || MemCE !== 1'b0) begin
            failures++;
            $display("FAIL single_done_end d0=%b ce=%b required 0 0", Done0, MemCE);
        end
    endtask

    task automatic test_round_robin();
        logic w;
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        Req0 = 1'b1; Addr0 = 20'hA0000; Data0 = 16'h0A0A;
        Req1 = 1'b1; Addr1 = 20'hB0000; Data1 = 16'h0B0B;
        MemYield = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = i[0];
            tick();
            checks++;
            if (Grant0 !== ~w || Grant1 !== w || MemCE !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant%0d g0=%b g1=%b ce=%b required winner %0d", i,
                         Grant0, Grant1, MemCE, w);
            end
            checks++;
            if (MemAddressOut !== (w ? 20'hB0000 : 20'hA0000)) begin
                failures++;
                $display("FAIL rr_addr%0d a=%h required %h", i, MemAddressOut,
                         w ? 20'hB0000 : 20'hA0000);
            end
            tick(); tick();
            MemDone = 1'b1;
            tick();
            MemDone = 1'b0;
            checks++;
            if (Done0 !== ~w || Done1 !== w || MemCE !== 1'b0) begin
                failures++;
                $display("FAIL rr_done%0d d0=%b d1=%b ce=%b required winner %0d ce 0", i,
                         Done0, Done1, MemCE, w);
            end
            if (i == 3) begin
                Req0 = 1'b0; Req1 = 1'b0;
            end
            tick();
            checks++;
            if (MemCE !== 1'b0 || Grant0 !== 1'b0 || Grant1 !== 1'b0) begin
                failures++;
                $display("FAIL rr_gap%0d ce=%b g0=%b g1=%b required 0 0 0", i, MemCE, Grant0, Grant1);
            end
        end
    endtask

    task automatic test_yield();
        int bad = 0;
        MemYield = 1'b0;
        Req1 = 1'b1; Addr1 = 20'h0CAFE; Data1 = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (Grant1 !== 1'b0 || MemCE !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL yield_hold grant_cycles=%0d required 0", bad);
        end
        MemYield = 1'b1;
        tick();
        checks++;
        if (Grant1 !== 1'b1 || MemCE !== 1'b1 || MemAddressOut !== 20'h0CAFE) begin
            failures++;
            $display("FAIL yield_grant g1=%b ce=%b a=%h required 1 1 0cafe", Grant1, MemCE, MemAddressOut);
        end
        MemDone = 1'b1;
        tick();
        MemDone = 1'b0; Req1 = 1'b0;
        checks++;
        if (Done1 !== 1'b1) begin
            failures++;
            $display("FAIL yield_done d1=%b required 1", Done1);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n = 1;
        Req1 = 1'b1; Addr1 = 20'h00777;
        tick();
        checks++;
        if (Grant1 !== 1'b1 || MemCE !== 1'b1) begin
            failures++;
            $display("FAIL to_grant g1=%b ce=%b required 1 1", Grant1, MemCE);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (MemCE !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL to_ce_cycles got=%0d required 8", n);
        end
        checks++;
        if (Done1 !== 1'b1 || TimeoutErr !== 1'b1 || Grant1 !== 1'b0 || Done0 !== 1'b0) begin
            failures++;
            $display("FAIL to_pulse d1=%b to=%b g1=%b d0=%b required 1 1 0 0",
                     Done1, TimeoutErr, Grant1, Done0);
        end
        Req1 = 1'b0;
        tick();
        checks++;
        if (Done1 !== 1'b0 || TimeoutErr !== 1'b0) begin
            failures++;
            $display("FAIL to_pulse_end d1=%b to=%b required 0 0", Done1, TimeoutErr);
        end
        tick();
    endtask

    task automatic test_done_timeout_tie();
        Req0 = 1'b1; Addr0 = 20'h00200;
        tick();
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (MemCE !== 1'b1 || Grant0 !== 1'b1) begin
            failures++;
            $display("FAIL tie_busy ce=%b g0=%b required 1 1", MemCE, Grant0);
        end
        MemDone = 1'b1;
        tick();
        MemDone = 1'b0; Req0 = 1'b0;
        checks++;
        if (Done0 !== 1'b1 || TimeoutErr !== 1'b0 || MemCE !== 1'b0) begin
            failures++;
            $display("FAIL tie_done d0=%b to=%b ce=%b required 1 0 0", Done0, TimeoutErr, MemCE);
        end
        tick();
    endtask

    task automatic test_ignore_changes();
        Req0 = 1'b1; Addr0 = 20'h12345; Data0 = 16'h1111;
        tick();
        Req0 = 1'b0; Addr0 = 20'h54321; Data0 = 16'h2222;
        tick();
        checks++;
        if (MemAddressOut !== 20'h12345 || MemDataOut !== 16'h1111 || Grant0 !== 1'b1 || MemCE !== 1'b1) begin
            failures++;
            $display("FAIL ign_hold a=%h d=%h g0=%b ce=%b required 12345 1111 1 1",
                     MemAddressOut, MemDataOut, Grant0, MemCE);
        end
        MemDone = 1'b1;
        tick();
        MemDone = 1'b0;
        checks++;
        if (Done0 !== 1'b1 || TimeoutErr !== 1'b0) begin
            failures++;
            $display("FAIL ign_done d0=%b to=%b required 1 0", Done0, TimeoutErr);
        end
        tick(); tick();
        checks++;
        if (MemCE !== 1'b0 || Grant0 !== 1'b0) begin
            failures++;
            $display("FAIL ign_idle ce=%b g0=%b required 0 0", MemCE, Grant0);
        end
    endtask

    task automatic test_async_reset();
        int dn = 0;
        Req0 = 1'b1; Addr0 = 20'h00300;
        tick(); tick(); tick();
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (MemCE !== 1'b0 || Grant0 !== 1'b0) begin
            failures++;
            $display("FAIL arst_drop ce=%b g0=%b required 0 0", MemCE, Grant0);
        end
        Req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Done0 !== 1'b0 || Done1 !== 1'b0) dn++;
        end
        Reset_n = 1'b1;
        tick();
        if (Done0 !== 1'b0 || Done1 !== 1'b0) dn++;
        checks++;
        if (dn != 0) begin
            failures++;
            $display("FAIL arst_no_done done_cycles=%0d required 0", dn);
        end
        Req0 = 1'b1; Req1 = 1'b1; Addr0 = 20'h00400; Addr1 = 20'h00500;
        tick();
        checks++;
        if (Grant0 !== 1'b1 || Grant1 !== 1'b0 || MemAddressOut !== 20'h00400) begin
            failures++;
            $display("FAIL arst_first g0=%b g1=%b a=%h required 1 0 00400", Grant0, Grant1, MemAddressOut);
        end
        Req1 = 1'b0;
        MemDone = 1'b1;
        tick();
        MemDone = 1'b0; Req0 = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_yield();
        test_timeout();
        test_done_timeout_tie();
        test_ignore_changes();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
